// File: rtl/mat_loader_4x2_2x2_if.sv
// Purpose : Handshake and operand bus between the element stream source, the
//           operand loader and the downstream 4x2 * 2x2 multiplier.
// Signals : in_data/in_valid/in_last/in_ready - element stream (valid/ready)
//           A0..A7, B0..B3                   - assembled operands (row-major)
//           out_valid/out_ready              - operand-set handshake
//           frame_err                        - one-cycle framing error pulse
//           frame_cnt                        - delivered frame counter
// Modports: slave  - loader side (drives in_ready and all operand outputs)
//           master - environment side (drives the stream and out_ready)
interface mat_loader_4x2_2x2_if #(
   parameter int DW = 4
);
   logic [DW-1:0] in_data;
   logic          in_valid;
   logic          in_last;
   logic          in_ready;
   logic [DW-1:0] A0, A1, A2, A3, A4, A5, A6, A7;
   logic [DW-1:0] B0, B1, B2, B3;
   logic          out_valid;
   logic          out_ready;
   logic          frame_err;
   logic [7:0]    frame_cnt;

   modport slave (
      input  in_data, in_valid, in_last, out_ready,
      output in_ready, A0, A1, A2, A3, A4, A5, A6, A7,
      output B0, B1, B2, B3, out_valid, frame_err, frame_cnt
   );

   modport master (
      output in_data, in_valid, in_last, out_ready,
      input  in_ready, A0, A1, A2, A3, A4, A5, A6, A7,
      input  B0, B1, B2, B3, out_valid, frame_err, frame_cnt
   );
endinterface

// File: rtl/mat_loader_4x2_2x2.sv
// Purpose : Operand loader for the 4x2 * 2x2 multiplier. Collects a frame of
//           12 serial elements (A0..A7 then B0..B3), checks framing with
//           in_last and holds the full operand set until the consumer takes it.
// Ports   : clk   - rising-edge clock
//           rst_n - synchronous active-low reset
//           bus   - mat_loader_4x2_2x2_if.slave (stream in, operands out)
module mat_loader_4x2_2x2 #(
   parameter int DW = 4
) (
   input logic                  clk,
   input logic                  rst_n,
   mat_loader_4x2_2x2_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_FULL  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [DW-1:0] a_q [0:7];
   logic [DW-1:0] a_d [0:7];
   logic [DW-1:0] b_q [0:3];
   logic [DW-1:0] b_d [0:3];
   logic          in_ready_q, in_ready_d;
   logic          out_valid_q, out_valid_d;
   logic          frame_err_q, frame_err_d;
   logic [7:0]    frame_cnt_q, frame_cnt_d;
   logic          beat_s;

   // in_ready comes from a register, so the accept decision never depends
   // combinationally on the stream inputs.
   assign beat_s = bus.in_valid & in_ready_q;

   // Next-state, operand write and framing-error decisions.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      a_d         = a_q;
      b_d         = b_q;
      frame_err_d = 1'b0;
      frame_cnt_d = frame_cnt_q;
      case (state_q)
         ST_LOAD: begin
            if (beat_s) begin
               if (cnt_q == 4'd11) begin
                  if (bus.in_last) begin
                     b_d[3]  = bus.in_data;
                     cnt_d   = 4'd0;
                     state_d = ST_FULL;
                  end else begin
                     // 12th element without in_last: resync on the next last
                     frame_err_d = 1'b1;
                     cnt_d       = 4'd0;
                     state_d     = ST_DRAIN;
                  end
               end else if (bus.in_last) begin
                  // early last: drop the element, restart at A0, keep partial A/B
                  frame_err_d = 1'b1;
                  cnt_d       = 4'd0;
               end else begin
                  if (cnt_q < 4'd8) begin
                     a_d[cnt_q[2:0]] = bus.in_data;
                  end else begin
                     b_d[cnt_q[1:0]] = bus.in_data;
                  end
                  cnt_d = cnt_q + 4'd1;
               end
            end else begin
               cnt_d = cnt_q;
            end
         end
         ST_DRAIN: begin
            if (beat_s && bus.in_last) begin
               cnt_d   = 4'd0;
               state_d = ST_LOAD;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         ST_FULL: begin
            if (bus.out_ready) begin
               frame_cnt_d = frame_cnt_q + 8'd1;
               state_d     = ST_LOAD;
            end else begin
               state_d = ST_FULL;
            end
         end
         default: begin
            cnt_d   = 4'd0;
            state_d = ST_LOAD;
         end
      endcase
      in_ready_d  = (state_d != ST_FULL);
      out_valid_d = (state_d == ST_FULL);
   end

   // State, operand and status registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_LOAD;
         cnt_q       <= 4'd0;
         a_q         <= '{default: '0};
         b_q         <= '{default: '0};
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         frame_err_q <= 1'b0;
         frame_cnt_q <= 8'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         a_q         <= a_d;
         b_q         <= b_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         frame_err_q <= frame_err_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.frame_err = frame_err_q;
   assign bus.frame_cnt = frame_cnt_q;
   assign bus.A0 = a_q[0];
   assign bus.A1 = a_q[1];
   assign bus.A2 = a_q[2];
   assign bus.A3 = a_q[3];
   assign bus.A4 = a_q[4];
   assign bus.A5 = a_q[5];
   assign bus.A6 = a_q[6];
   assign bus.A7 = a_q[7];
   assign bus.B0 = b_q[0];
   assign bus.B1 = b_q[1];
   assign bus.B2 = b_q[2];
   assign bus.B3 = b_q[3];

endmodule

// File: tb/tb_mat_loader_4x2_2x2.sv
// Self-checking bench for mat_loader_4x2_2x2: directed framing scenarios and
// a randomized stream, compared every cycle against a frame-level model.
module tb_mat_loader_4x2_2x2;
   localparam int DW = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mat_loader_4x2_2x2_if #(.DW(DW)) bus ();
   mat_loader_4x2_2x2 #(.DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   logic [3:0] dA [0:7];
   logic [3:0] dB [0:3];
   assign dA[0] = bus.A0; assign dA[1] = bus.A1; assign dA[2] = bus.A2; assign dA[3] = bus.A3;
   assign dA[4] = bus.A4; assign dA[5] = bus.A5; assign dA[6] = bus.A6; assign dA[7] = bus.A7;
   assign dB[0] = bus.B0; assign dB[1] = bus.B1; assign dB[2] = bus.B2; assign dB[3] = bus.B3;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Downstream product element S(2r+c) computed from the presented operands.
   function automatic int s_elem(input int k);
      int r, c;
      r = k / 2;
      c = k % 2;
      return dA[2*r] * dB[c] + dA[2*r+1] * dB[2+c];
   endfunction

   // ---------------- frame-level reference model ----------------
   bit         m_full, m_drain, m_err;
   logic [7:0] m_fcnt;
   logic [3:0] m_A [0:7];
   logic [3:0] m_B [0:3];
   logic [3:0] m_cur [$];
   int         m_k;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_full = 0; m_drain = 0; m_err = 0; m_fcnt = 8'd0;
         for (int i = 0; i < 8; i++) m_A[i] = 4'd0;
         for (int i = 0; i < 4; i++) m_B[i] = 4'd0;
         m_cur.delete();
      end else begin
         m_err = 0;
         if (m_full) begin
            if (bus.out_ready) begin
               m_full = 0;
               m_fcnt = m_fcnt + 8'd1;
            end
         end else if (bus.in_valid) begin
            if (m_drain) begin
               if (bus.in_last) m_drain = 0;
            end else if (m_cur.size() == 11) begin
               if (bus.in_last) begin
                  m_B[3] = bus.in_data;
                  m_full = 1;
               end else begin
                  m_err   = 1;
                  m_drain = 1;
               end
               m_cur.delete();
            end else if (bus.in_last) begin
               m_err = 1;
               m_cur.delete();
            end else begin
               m_k = m_cur.size();
               if (m_k < 8) m_A[m_k] = bus.in_data;
               else         m_B[m_k-8] = bus.in_data;
               m_cur.push_back(bus.in_data);
            end
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("in_ready", bus.in_ready, !m_full);
         chk("out_valid", bus.out_valid, m_full);
         chk("frame_err", bus.frame_err, m_err);
         chk("frame_cnt", bus.frame_cnt, m_fcnt);
         for (int i = 0; i < 8; i++) chk($sformatf("A%0d", i), dA[i], m_A[i]);
         for (int i = 0; i < 4; i++) chk($sformatf("B%0d", i), dB[i], m_B[i]);
      end
   end

   // ---------------- stimulus ----------------
   logic [3:0] fv [0:11];

   task automatic cyc(input logic v, input logic [3:0] d, input logic l, input logic o);
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.in_last   = l;
      bus.out_ready = o;
      @(posedge clk);
      #2;
   endtask

   task automatic send_frame();
      for (int i = 0; i < 12; i++) cyc(1'b1, fv[i], (i == 11), 1'b0);
   endtask

   task automatic handoff();
      cyc(1'b0, 4'd0, 1'b0, 1'b1);
   endtask

   int errs;

   initial begin
      bus.in_valid = 1'b0; bus.in_data = 4'd0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #2;
      chk_en = 1'b1;
      @(posedge clk); #2;

      // 1. reset state
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_frame_err", bus.frame_err, 0);
      chk("rst_frame_cnt", bus.frame_cnt, 0);
      for (int i = 0; i < 8; i++) chk($sformatf("rst_A%0d", i), dA[i], 0);
      for (int i = 0; i < 4; i++) chk($sformatf("rst_B%0d", i), dB[i], 0);
      rst_n = 1'b1;

      // 2. stream 1..12
      for (int i = 0; i < 12; i++) fv[i] = 4'(i + 1);
      send_frame();
      chk("t2_out_valid", bus.out_valid, 1);
      chk("t2_in_ready", bus.in_ready, 0);
      for (int i = 0; i < 8; i++) chk($sformatf("t2_A%0d", i), dA[i], i + 1);
      for (int i = 0; i < 4; i++) chk($sformatf("t2_B%0d", i), dB[i], i + 9);
      chk("t2_S0", s_elem(0), 31);
      chk("t2_S1", s_elem(1), 34);
      chk("t2_S6", s_elem(6), 151);
      handoff();
      chk("t2_valid_drop", bus.out_valid, 0);
      chk("t2_frame_cnt", bus.frame_cnt, 1);

      // 3. back-pressure: operands held while in_valid keeps toggling data
      for (int i = 0; i < 12; i++) fv[i] = 4'($urandom);
      send_frame();
      for (int c = 0; c < 5; c++) begin
         cyc(1'b1, 4'($urandom), 1'($urandom), 1'b0);
         chk("t3_out_valid", bus.out_valid, 1);
         chk("t3_in_ready", bus.in_ready, 0);
         for (int i = 0; i < 8; i++) chk($sformatf("t3_A%0d", i), dA[i], fv[i]);
         for (int i = 0; i < 4; i++) chk($sformatf("t3_B%0d", i), dB[i], fv[8+i]);
      end
      handoff();
      chk("t3_valid_drop", bus.out_valid, 0);
      chk("t3_frame_cnt", bus.frame_cnt, 2);

      // 4. early last on beat 5
      for (int i = 0; i < 4; i++) cyc(1'b1, 4'(i), 1'b0, 1'b0);
      cyc(1'b1, 4'd4, 1'b1, 1'b0);
      chk("t4_err_pulse", bus.frame_err, 1);
      chk("t4_out_valid", bus.out_valid, 0);
      cyc(1'b0, 4'd0, 1'b0, 1'b0);
      chk("t4_err_clear", bus.frame_err, 0);
      for (int i = 0; i < 12; i++) fv[i] = 4'd15;
      send_frame();
      for (int k = 0; k < 8; k++) chk($sformatf("t4_S%0d", k), s_elem(k), 450);
      handoff();
      chk("t4_frame_cnt", bus.frame_cnt, 3);

      // 5. missing last, then drain until a last
      errs = 0;
      for (int i = 0; i < 12; i++) begin
         cyc(1'b1, 4'd5, 1'b0, 1'b0);
         errs += int'(bus.frame_err);
      end
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 4'd6, (i == 2), 1'b0);
         errs += int'(bus.frame_err);
      end
      cyc(1'b0, 4'd0, 1'b0, 1'b0);
      errs += int'(bus.frame_err);
      chk("t5_err_count", errs, 1);
      chk("t5_out_valid", bus.out_valid, 0);
      for (int i = 0; i < 12; i++) fv[i] = 4'(i + 1);
      send_frame();
      chk("t5_A0", bus.A0, 1);
      chk("t5_B3", bus.B3, 12);
      handoff();

      // 6a. reset mid-frame
      for (int i = 0; i < 7; i++) cyc(1'b1, 4'd9, 1'b0, 1'b0);
      rst_n = 1'b0;
      cyc(1'b0, 4'd0, 1'b0, 1'b0);
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) fv[i] = 4'(i + 3);
      send_frame();
      chk("t6_A0", bus.A0, 3);
      chk("t6_A7", bus.A7, 10);
      chk("t6_B0", bus.B0, 11);
      chk("t6_frame_cnt", bus.frame_cnt, 0);
      handoff();
      chk("t6_frame_cnt_after", bus.frame_cnt, 1);

      // 6b. frame counter wrap
      rst_n = 1'b0;
      cyc(1'b0, 4'd0, 1'b0, 1'b0);
      rst_n = 1'b1;
      for (int f = 0; f < 256; f++) begin
         for (int i = 0; i < 12; i++) fv[i] = 4'($urandom);
         send_frame();
         handoff();
         if (f == 254) chk("t6_cnt_255", bus.frame_cnt, 255);
      end
      chk("t6_cnt_wrap", bus.frame_cnt, 0);

      // 7. randomized stream with random gaps, framing and back-pressure
      for (int c = 0; c < 3000; c++) begin
         logic l;
         if (m_cur.size() == 11 && !m_drain) l = ($urandom % 8 != 0);
         else                                l = ($urandom % 16 == 0);
         cyc(($urandom % 4 != 0), 4'($urandom), l, ($urandom % 3 == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
